// File: rtl/mips_irq_pkg.sv
// Shared constants, register offsets and FSM encoding for the mips_irq_ctl interrupt controller.
package mips_irq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned OFF_W  = 5;

    localparam logic [OFF_W-1:0] IRQ_OFF_PEND = 5'h00;
    localparam logic [OFF_W-1:0] IRQ_OFF_MASK = 5'h04;
    localparam logic [OFF_W-1:0] IRQ_OFF_VEC  = 5'h08;
    localparam logic [OFF_W-1:0] IRQ_OFF_EOI  = 5'h0C;
    localparam logic [OFF_W-1:0] IRQ_OFF_STAT = 5'h10;

    // Word-store access code on the core's mem_ctl bus
    localparam logic [3:0] IRQ_MEM_SW = 4'b1100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Handler address for a source: base plus id scaled by the vector stride
    function automatic logic [DATA_W-1:0] vec_addr(
        input logic [DATA_W-1:0] base,
        input logic [ID_W-1:0]   id,
        input int unsigned       shift
    );
        return base + (DATA_W'(id) << shift);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 is the highest priority source.
module irq_prio_enc
    import mips_irq_pkg::*;
#(
    parameter int unsigned NSRC = 8
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scan downwards so the last hit written is the lowest set index
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/mips_irq_ctl.sv
// Memory-mapped interrupt controller: pending/mask registers, fixed priority, one request at a time.
// Define IRQ_LEVEL_EN for level-sensitive sources; default build detects rising edges.
module mips_irq_ctl
    import mips_irq_pkg::*;
#(
    parameter int unsigned       NSRC      = 8,
    parameter logic [DATA_W-1:0] BASE_ADDR = 32'h0000_7F00,
    parameter logic [DATA_W-1:0] VEC_RESET = 32'h0000_0050,
    parameter int unsigned       VEC_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   irq_src_i,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic [3:0]        mem_ctl,
    output logic [DATA_W-1:0] dout,
    output logic              irq_req_o,
    output logic [DATA_W-1:0] irq_addr_o
);

    localparam logic [DATA_W-1:0] VEC_LOW = (DATA_W'(1) << VEC_SHIFT) - DATA_W'(1);

    irq_state_e        state_q, state_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic              irq_req_d;
    logic [DATA_W-1:0] irq_addr_d;
    logic [NSRC-1:0]   mask_q;
    logic [DATA_W-1:0] vec_base_q;
    logic [NSRC-1:0]   pending;
    logic              enc_valid;
    logic [ID_W-1:0]   enc_id;
    logic              hit;
    logic [OFF_W-1:0]  off;
    logic              wr;
    logic              wr_eoi;
    logic              in_service;

    // Bus decode
    assign hit        = (addr[DATA_W-1:OFF_W] == BASE_ADDR[DATA_W-1:OFF_W]);
    assign off        = addr[OFF_W-1:0];
    assign wr         = hit && (mem_ctl == IRQ_MEM_SW);
    assign wr_eoi     = wr && (off == IRQ_OFF_EOI);
    assign in_service = (state_q == SERVICE);

    // MASK and VEC_BASE registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= '0;
            vec_base_q <= VEC_RESET;
        end else if (wr) begin
            if (off == IRQ_OFF_MASK) mask_q     <= din[NSRC-1:0];
            if (off == IRQ_OFF_VEC)  vec_base_q <= din & ~VEC_LOW;
        end
    end

`ifdef IRQ_LEVEL_EN
    // Level mode: pending is simply the enabled live lines
    assign pending = irq_src_i & mask_q;
`else
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pend_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] req_clr;

    assign rise    = irq_src_i & ~src_q;
    assign w1c     = (wr && (off == IRQ_OFF_PEND)) ? din[NSRC-1:0] : '0;
    assign req_clr = (state_q == REQ) ? (NSRC'(1) << cur_id_q) : '0;

    // A new edge wins over any clear landing on the same bit
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= '0;
            pend_q <= '0;
        end else begin
            src_q  <= irq_src_i;
            pend_q <= (pend_q & ~w1c & ~req_clr) | rise;
        end
    end

    assign pending = pend_q;
`endif

    irq_prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .req   (pending & mask_q),
        .valid (enc_valid),
        .id    (enc_id)
    );

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_id_q   <= '0;
            irq_req_o  <= 1'b0;
            irq_addr_o <= VEC_RESET;
        end else begin
            state_q    <= state_d;
            cur_id_q   <= cur_id_d;
            irq_req_o  <= irq_req_d;
            irq_addr_o <= irq_addr_d;
        end
    end

    // Next state: latch winner in IDLE, pulse in REQ, hold in SERVICE until EOI
    always_comb begin
        state_d    = state_q;
        cur_id_d   = cur_id_q;
        irq_req_d  = 1'b0;
        irq_addr_d = irq_addr_o;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    cur_id_d   = enc_id;
                    irq_addr_d = vec_addr(vec_base_q, enc_id, VEC_SHIFT);
                    irq_req_d  = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ:     state_d = SERVICE;
            SERVICE: if (wr_eoi) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read mux, combinational from the address
    always_comb begin
        dout = '0;
        if (hit) begin
            case (off)
                IRQ_OFF_PEND: dout = DATA_W'(pending);
                IRQ_OFF_MASK: dout = DATA_W'(mask_q);
                IRQ_OFF_VEC:  dout = vec_base_q;
                IRQ_OFF_STAT: dout = {27'b0, in_service, cur_id_q};
                default:      dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_irq_ctl.sv
// Scoreboard bench for mips_irq_ctl: stimulus queues expectations, a negedge monitor checks them.
module tb_mips_irq_ctl;
    import mips_irq_pkg::*;

    localparam int unsigned NSRC = 8;
    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NSRC-1:0] src = '0;
    logic [31:0]     addr = '0;
    logic [31:0]     din = '0;
    logic [3:0]      mem_ctl = '0;
    logic [31:0]     dout;
    logic            irq_req;
    logic [31:0]     irq_addr;

    mips_irq_ctl #(.NSRC(NSRC)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src_i  (src),
        .addr       (addr),
        .din        (din),
        .mem_ctl    (mem_ctl),
        .dout       (dout),
        .irq_req_o  (irq_req),
        .irq_addr_o (irq_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } irq_exp_t;

    typedef struct {
        bit          sel;
        logic [31:0] val;
    } probe_t;

    irq_exp_t irq_q[$];
    probe_t   pr_q[$];
    string    pr_name[$];
    bit       probe_vld = 1'b0;
    bit       done = 1'b0;
    int       total = 0;
    int       bad = 0;

    irq_exp_t    e;
    probe_t      p;
    string       nm;
    logic [31:0] act;

    // Monitor: every request must match the head of irq_q; probes compare dout or irq_addr
    always @(negedge clk) begin
        if (!rst) begin
            if (irq_req) begin
                total++;
                if (irq_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_irq cyc=%0d got_addr=%h want=no_request", cyc, irq_addr);
                end else begin
                    e = irq_q.pop_front();
                    if (irq_addr !== e.addr || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL irq got addr=%h cyc=%0d want addr=%h cyc=%0d",
                                 irq_addr, cyc, e.addr, e.cyc);
                    end
                end
            end
            if (probe_vld && pr_q.size() != 0) begin
                p  = pr_q.pop_front();
                nm = pr_name.pop_front();
                act = p.sel ? irq_addr : dout;
                total++;
                if (act !== p.val) begin
                    bad++;
                    $display("FAIL %s got=%h want=%h", nm, act, p.val);
                end
            end
        end
        if (done || cyc > 20000) begin
            total++;
            if (cyc > 20000) begin
                bad++;
                $display("FAIL watchdog cyc=%0d", cyc);
            end else if (irq_q.size() != 0) begin
                bad++;
                $display("FAIL missing_irq got=0 want=%0d more requests", irq_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [4:0] off, input logic [31:0] d);
        addr    = BASE | 32'(off);
        din     = d;
        mem_ctl = IRQ_MEM_SW;
        tick();
        mem_ctl = 4'h0;
        addr    = '0;
    endtask

    task automatic rd(input logic [4:0] off, input logic [31:0] v, input string name);
        addr = BASE | 32'(off);
        pr_q.push_back('{1'b0, v});
        pr_name.push_back(name);
        probe_vld = 1'b1;
        tick();
        probe_vld = 1'b0;
        addr = '0;
    endtask

    task automatic chk_addr(input logic [31:0] v, input string name);
        pr_q.push_back('{1'b1, v});
        pr_name.push_back(name);
        probe_vld = 1'b1;
        tick();
        probe_vld = 1'b0;
    endtask

    task automatic expect_irq(input logic [31:0] a, input int dc);
        irq_q.push_back('{a, cyc + dc});
    endtask

    task automatic pulse(input logic [NSRC-1:0] m);
        src = src | m;
        tick();
        src = src & ~m;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;

        // Reset state and quiet period
        rd(IRQ_OFF_VEC,  32'h50, "rst_vec");
        rd(IRQ_OFF_PEND, 32'h00, "rst_pend");
        rd(IRQ_OFF_MASK, 32'h00, "rst_mask");
        rd(IRQ_OFF_STAT, 32'h00, "rst_stat");
        chk_addr(32'h50, "rst_irq_addr");
        repeat (20) tick();

`ifdef IRQ_LEVEL_EN
        // Held line re-requests after EOI; dropped line does not
        bus_wr(IRQ_OFF_MASK, 32'h40);
        expect_irq(32'h80, 1);
        src[6] = 1'b1;
        tick();
        repeat (3) tick();
        rd(IRQ_OFF_STAT, 32'h16, "lvl_stat");
        expect_irq(32'h80, 2);
        bus_wr(IRQ_OFF_EOI, 32'h0);
        repeat (3) tick();
        src[6] = 1'b0;
        tick();
        bus_wr(IRQ_OFF_EOI, 32'h0);
        repeat (5) tick();
        rd(IRQ_OFF_STAT, 32'h06, "lvl_idle_stat");
        rd(IRQ_OFF_PEND, 32'h00, "lvl_pend_low");
`else
        // Single source, exact latency
        bus_wr(IRQ_OFF_MASK, 32'hFF);
        rd(IRQ_OFF_MASK, 32'hFF, "mask_rb");
        expect_irq(32'h68, 2);
        pulse(8'h08);
        repeat (3) tick();
        rd(IRQ_OFF_STAT, 32'h13, "stat_svc3");
        rd(IRQ_OFF_PEND, 32'h00, "pend_cleared");
        bus_wr(IRQ_OFF_EOI, 32'h0);
        rd(IRQ_OFF_STAT, 32'h03, "stat_eoi3");
        chk_addr(32'h68, "addr_hold");
        repeat (3) tick();

        // Two simultaneous edges: priority then queued service
        expect_irq(32'h60, 2);
        pulse(8'h24);
        repeat (3) tick();
        rd(IRQ_OFF_STAT, 32'h12, "stat_svc2");
        rd(IRQ_OFF_PEND, 32'h20, "pend_id5_wait");
        expect_irq(32'h78, 2);
        bus_wr(IRQ_OFF_EOI, 32'h0);
        repeat (3) tick();
        rd(IRQ_OFF_STAT, 32'h15, "stat_svc5");
        bus_wr(IRQ_OFF_EOI, 32'h0);
        repeat (2) tick();

        // Masked pending, unmask, set-beats-W1C, W1C, EOI in IDLE
        bus_wr(IRQ_OFF_MASK, 32'h00);
        pulse(8'h02);
        repeat (3) tick();
        rd(IRQ_OFF_PEND, 32'h02, "pend_masked");
        expect_irq(32'h58, 2);
        bus_wr(IRQ_OFF_MASK, 32'h02);
        repeat (3) tick();
        rd(IRQ_OFF_STAT, 32'h11, "stat_svc1");
        rd(IRQ_OFF_PEND, 32'h00, "pend1_cleared");
        pulse(8'h02);
        tick();
        rd(IRQ_OFF_PEND, 32'h02, "pend_in_service");
        src[1] = 1'b1;
        bus_wr(IRQ_OFF_PEND, 32'h02);
        src[1] = 1'b0;
        tick();
        rd(IRQ_OFF_PEND, 32'h02, "set_beats_w1c");
        bus_wr(IRQ_OFF_PEND, 32'h02);
        rd(IRQ_OFF_PEND, 32'h00, "w1c_clear");
        bus_wr(IRQ_OFF_EOI, 32'h0);
        repeat (4) tick();
        rd(IRQ_OFF_STAT, 32'h01, "stat_idle1");
        bus_wr(IRQ_OFF_EOI, 32'h0);
        repeat (4) tick();
        rd(IRQ_OFF_STAT, 32'h01, "eoi_idle_ignored");

        // Edge during SERVICE waits for EOI; config changes don't disturb service; reset mid-service
        bus_wr(IRQ_OFF_VEC, 32'h200);
        bus_wr(IRQ_OFF_MASK, 32'hFF);
        expect_irq(32'h220, 2);
        pulse(8'h10);
        repeat (3) tick();
        rd(IRQ_OFF_STAT, 32'h14, "stat_svc4");
        pulse(8'h01);
        repeat (4) tick();
        rd(IRQ_OFF_PEND, 32'h01, "pend0_waiting");
        expect_irq(32'h200, 2);
        bus_wr(IRQ_OFF_EOI, 32'h0);
        repeat (3) tick();
        rd(IRQ_OFF_STAT, 32'h10, "stat_svc0");
        bus_wr(IRQ_OFF_VEC, 32'h307);
        rd(IRQ_OFF_VEC, 32'h300, "vec_low_forced");
        bus_wr(IRQ_OFF_MASK, 32'h00);
        chk_addr(32'h200, "addr_stable_in_service");
        rd(IRQ_OFF_STAT, 32'h10, "id_stable");
        pulse(8'h80);
        tick();
        rd(IRQ_OFF_PEND, 32'h80, "pend7_before_rst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(IRQ_OFF_VEC,  32'h50, "rst2_vec");
        rd(IRQ_OFF_PEND, 32'h00, "rst2_pend");
        rd(IRQ_OFF_MASK, 32'h00, "rst2_mask");
        rd(IRQ_OFF_STAT, 32'h00, "rst2_stat");
        chk_addr(32'h50, "rst2_irq_addr");
`endif

        repeat (5) tick();
        done = 1'b1;
        repeat (2) tick();
    end

endmodule
